// File: rtl/biquad_mac_sched.sv
// biquad_mac_sched
//   Time-multiplexed scheduler for a two-section cascaded biquad bandpass.
//   Runs on the fast system clock. Each accepted PCM sample goes through both
//   sections using one shared 16x16 signed multiplier and one accumulator.
//   Coefficients are snapshotted when a sample is accepted, so port changes
//   never tear an in-flight computation.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   pcm_valid, d_in     one-cycle sample strobe and signed 16-bit sample
//   B*_0 / A*_0         section 0 coefficients, signed Q2.14
//   B*_1 / A*_1         section 1 coefficients, signed Q2.14
//   clear_state         zeros all delay lines (only acted on when idle)
//   busy                high while a sample is in flight
//   out_valid, d_out    one-cycle result strobe and held filtered sample
//   sat                 sticky: a section output was clipped
//   overrun             sticky: pcm_valid arrived while busy (sample dropped)
module biquad_mac_sched #(
    parameter int ACC_W = 36,
    parameter int FRAC  = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcm_valid,
    input  logic [15:0] d_in,
    input  logic [15:0] B0_0,
    input  logic [15:0] B1_0,
    input  logic [15:0] B2_0,
    input  logic [15:0] A1_0,
    input  logic [15:0] A2_0,
    input  logic [15:0] B0_1,
    input  logic [15:0] B1_1,
    input  logic [15:0] B2_1,
    input  logic [15:0] A1_1,
    input  logic [15:0] A2_1,
    input  logic        clear_state,
    output logic        busy,
    output logic        out_valid,
    output logic [15:0] d_out,
    output logic        sat,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE,
        MAC0,
        WB0,
        MAC1,
        WB1
    } state_t;

    state_t state, state_nx;

    logic [2:0]              tap;
    logic signed [ACC_W-1:0] acc;
    logic signed [15:0]      x_cur;

    // Coefficient snapshots, indexed by section.
    logic signed [15:0] sh_b0 [2];
    logic signed [15:0] sh_b1 [2];
    logic signed [15:0] sh_b2 [2];
    logic signed [15:0] sh_a1 [2];
    logic signed [15:0] sh_a2 [2];

    // Delay lines, indexed by section.
    logic signed [15:0] x1 [2];
    logic signed [15:0] x2 [2];
    logic signed [15:0] y1 [2];
    logic signed [15:0] y2 [2];

    logic                    sec;
    logic signed [15:0]      mul_a;
    logic signed [15:0]      mul_b;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_nx;
    logic signed [ACC_W-1:0] acc_sh;
    logic signed [15:0]      y_sat;
    logic                    clip;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        sec      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (pcm_valid) begin
                    state_nx = MAC0;
                end
            end
            MAC0: begin
                if (tap == 3'd4) begin
                    state_nx = WB0;
                end
            end
            WB0: begin
                state_nx = MAC1;
            end
            MAC1: begin
                sec = 1'b1;
                if (tap == 3'd4) begin
                    state_nx = WB1;
                end
            end
            WB1: begin
                sec      = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ---------------- shared multiplier ----------------
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (tap)
            3'd0: begin
                mul_a = sh_b0[sec];
                mul_b = x_cur;
            end
            3'd1: begin
                mul_a = sh_b1[sec];
                mul_b = x1[sec];
            end
            3'd2: begin
                mul_a = sh_b2[sec];
                mul_b = x2[sec];
            end
            3'd3: begin
                mul_a = sh_a1[sec];
                mul_b = y1[sec];
            end
            default: begin
                mul_a = sh_a2[sec];
                mul_b = y2[sec];
            end
        endcase
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
    // Feedback taps (a1, a2) are subtracted.
    assign acc_nx   = (tap >= 3'd3) ? (acc - prod_ext) : (acc + prod_ext);

    // ---------------- write-back: floor shift and clip ----------------
    assign acc_sh = acc >>> FRAC;

    // In range exactly when every bit from 15 up matches the sign.
    always_comb begin
        clip  = 1'b0;
        y_sat = acc_sh[15:0];
        if (!((&acc_sh[ACC_W-1:15]) || !(|acc_sh[ACC_W-1:15]))) begin
            clip  = 1'b1;
            y_sat = acc_sh[ACC_W-1] ? 16'sh8000 : 16'sh7FFF;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tap       <= '0;
            acc       <= '0;
            x_cur     <= '0;
            sh_b0     <= '{default: '0};
            sh_b1     <= '{default: '0};
            sh_b2     <= '{default: '0};
            sh_a1     <= '{default: '0};
            sh_a2     <= '{default: '0};
            x1        <= '{default: '0};
            x2        <= '{default: '0};
            y1        <= '{default: '0};
            y2        <= '{default: '0};
            out_valid <= 1'b0;
            d_out     <= '0;
            sat       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (pcm_valid && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    tap <= '0;
                    if (pcm_valid) begin
                        x_cur    <= d_in;
                        acc      <= '0;
                        sh_b0[0] <= B0_0;
                        sh_b1[0] <= B1_0;
                        sh_b2[0] <= B2_0;
                        sh_a1[0] <= A1_0;
                        sh_a2[0] <= A2_0;
                        sh_b0[1] <= B0_1;
                        sh_b1[1] <= B1_1;
                        sh_b2[1] <= B2_1;
                        sh_a1[1] <= A1_1;
                        sh_a2[1] <= A2_1;
                    end else if (clear_state) begin
                        x1 <= '{default: '0};
                        x2 <= '{default: '0};
                        y1 <= '{default: '0};
                        y2 <= '{default: '0};
                    end
                end
                MAC0, MAC1: begin
                    acc <= acc_nx;
                    tap <= (tap == 3'd4) ? 3'd0 : tap + 3'd1;
                end
                WB0, WB1: begin
                    tap     <= '0;
                    acc     <= '0;
                    x2[sec] <= x1[sec];
                    x1[sec] <= x_cur;
                    y2[sec] <= y1[sec];
                    y1[sec] <= y_sat;
                    if (clip) begin
                        sat <= 1'b1;
                    end
                    if (state == WB0) begin
                        // Section 0 output becomes section 1 input.
                        x_cur <= y_sat;
                    end else begin
                        d_out     <= y_sat;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    tap <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biquad_mac_sched.sv
module tb_biquad_mac_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcm_valid = 1'b0;
    logic        clear_state = 1'b0;
    logic [15:0] d_in = '0;
    logic [15:0] cb0 [2];
    logic [15:0] cb1 [2];
    logic [15:0] cb2 [2];
    logic [15:0] ca1 [2];
    logic [15:0] ca2 [2];
    logic        busy;
    logic        out_valid;
    logic [15:0] d_out;
    logic        sat;
    logic        overrun;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: plain integer biquad cascade.
    int          mx1 [2];
    int          mx2 [2];
    int          my1 [2];
    int          my2 [2];
    bit          sat_m;
    bit          ovr_m;
    logic [15:0] dout_m;

    biquad_mac_sched #(.ACC_W(36), .FRAC(14)) dut (
        .clk(clk), .rst(rst), .pcm_valid(pcm_valid), .d_in(d_in),
        .B0_0(cb0[0]), .B1_0(cb1[0]), .B2_0(cb2[0]), .A1_0(ca1[0]), .A2_0(ca2[0]),
        .B0_1(cb0[1]), .B1_1(cb1[1]), .B2_1(cb2[1]), .A1_1(ca1[1]), .A2_1(ca2[1]),
        .clear_state(clear_state), .busy(busy), .out_valid(out_valid),
        .d_out(d_out), .sat(sat), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear_lines();
        for (int s = 0; s < 2; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
    endtask

    task automatic model_reset();
        model_clear_lines();
        sat_m  = 1'b0;
        ovr_m  = 1'b0;
        dout_m = '0;
    endtask

    function automatic logic [15:0] model_sample(input logic [15:0] d);
        int     x;
        longint acc;
        longint y;
        x = int'($signed(d));
        for (int s = 0; s < 2; s++) begin
            acc = longint'($signed(cb0[s])) * x
                + longint'($signed(cb1[s])) * mx1[s]
                + longint'($signed(cb2[s])) * mx2[s]
                - longint'($signed(ca1[s])) * my1[s]
                - longint'($signed(ca2[s])) * my2[s];
            y = acc >>> 14;
            if (y > 32767) begin
                y = 32767; sat_m = 1'b1;
            end else if (y < -32768) begin
                y = -32768; sat_m = 1'b1;
            end
            mx2[s] = mx1[s]; mx1[s] = x;
            my2[s] = my1[s]; my1[s] = int'(y);
            x = int'(y);
        end
        return 16'(x);
    endfunction

    task automatic set_sec(input int s, input int b0, input int b1, input int b2,
                           input int a1, input int a2);
        cb0[s] = 16'(b0); cb1[s] = 16'(b1); cb2[s] = 16'(b2);
        ca1[s] = 16'(a1); ca2[s] = 16'(a2);
    endtask

    // Idle for k cycles; no strobe and d_out must hold.
    task automatic quiet(input int k);
        int bad;
        bad = 0;
        for (int i = 0; i < k; i++) begin
            tick();
            if (out_valid !== 1'b0 || d_out !== dout_m) bad++;
        end
        chk("quiet_hold", bad, 0);
    endtask

    task automatic pulse_clear();
        clear_state = 1'b1;
        tick();
        clear_state = 1'b0;
        model_clear_lines();
    endtask

    // Sample index k is taken #1 after edge N+k; inputs set there hit edge N+k+1.
    // clr_at = -1 raises clear_state together with pcm_valid; -2 disables.
    task automatic send_sample(input logic [15:0] d, input int chg_at,
                               input logic [15:0] chg_val, input int ovr_at,
                               input int clr_at);
        logic [15:0] exp_y;
        int edges;
        int busy_n;
        exp_y = model_sample(d);
        if (ovr_at >= 0) ovr_m = 1'b1;
        d_in = d;
        pcm_valid = 1'b1;
        clear_state = (clr_at == -1);
        tick();
        pcm_valid = 1'b0;
        clear_state = 1'b0;
        d_in = 16'($urandom);
        edges = 0;
        busy_n = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_n++;
            if (edges == chg_at) cb0[1] = chg_val;
            if (edges == ovr_at) pcm_valid = 1'b1;
            if (edges == clr_at) clear_state = 1'b1;
            tick();
            pcm_valid = 1'b0;
            clear_state = 1'b0;
            edges++;
        end
        dout_m = exp_y;
        chk("latency", edges, 12);
        chk("busy_cycles", busy_n, 12);
        chk("busy_end", busy, 0);
        chk("d_out", $signed(d_out), $signed(exp_y));
        chk("sat", sat, sat_m);
        chk("overrun", overrun, ovr_m);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) set_sec(s, 0, 0, 0, 0, 0);
        model_reset();

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_sat", sat, 0);
        chk("rst_overrun", overrun, 0);
        quiet(3);

        // Impulse through section 0, section 1 passthrough
        set_sec(0, 8192, 8192, 0, 0, 0);
        set_sec(1, 16384, 0, 0, 0, 0);
        send_sample(16'd16384, -9, '0, -9, -2);
        chk("imp0", $signed(d_out), 8192);
        quiet(87);
        send_sample(16'd0, -9, '0, -9, -2);
        chk("imp1", $signed(d_out), 8192);
        quiet(87);
        send_sample(16'd0, -9, '0, -9, -2);
        chk("imp2", $signed(d_out), 0);
        quiet(5);

        // Recursion y = x + 0.5*y1
        set_sec(0, 16384, 0, 0, -8192, 0);
        pulse_clear();
        send_sample(16'd16384, -9, '0, -9, -2);
        chk("rec0", $signed(d_out), 16384);
        quiet(2);
        send_sample(16'd0, -9, '0, -9, -2);
        chk("rec1", $signed(d_out), 8192);
        quiet(2);
        send_sample(16'd0, -9, '0, -9, -2);
        chk("rec2", $signed(d_out), 4096);
        quiet(2);
        send_sample(16'd0, -9, '0, -9, 5);
        chk("rec3_clear_busy_ignored", $signed(d_out), 2048);
        quiet(2);
        send_sample(16'd0, -9, '0, -9, -1);
        chk("rec4_pcm_wins", $signed(d_out), 1024);
        quiet(2);
        pulse_clear();
        send_sample(16'd0, -9, '0, -9, -2);
        chk("clear_zero", $signed(d_out), 0);
        quiet(2);

        // Saturation, both polarities; sat is sticky
        set_sec(0, 32767, 0, 0, 0, 0);
        pulse_clear();
        send_sample(16'd32767, -9, '0, -9, -2);
        chk("sat_pos", $signed(d_out), 32767);
        chk("sat_set", sat, 1);
        quiet(4);
        send_sample(16'h8000, -9, '0, -9, -2);
        chk("sat_neg", $signed(d_out), -32768);
        quiet(4);

        // Overrun: second strobe 5 cycles after the first, then one at +13
        set_sec(0, 16384, 0, 0, 0, 0);
        pulse_clear();
        send_sample(16'd1234, -9, '0, 4, -2);
        chk("ovr_first", $signed(d_out), 1234);
        chk("ovr_flag", overrun, 1);
        send_sample(16'hF000, -9, '0, -9, -2);
        chk("ovr_next", $signed(d_out), -4096);
        quiet(6);

        // Coefficient snapshot: B0_1 changes mid-sample
        send_sample(16'd12000, 2, 16'd0, -9, -2);
        chk("snap_cur", $signed(d_out), 12000);
        quiet(3);
        send_sample(16'd5000, -9, '0, -9, -2);
        chk("snap_next", $signed(d_out), 0);
        quiet(3);

        // Randomised coefficients and samples, some back-to-back
        for (int n = 0; n < 24; n++) begin
            for (int s = 0; s < 2; s++) begin
                set_sec(s, int'($urandom_range(16383)) - 8192,
                        int'($urandom_range(16383)) - 8192,
                        int'($urandom_range(16383)) - 8192,
                        int'($urandom_range(8191)) - 4096,
                        int'($urandom_range(8191)) - 4096);
            end
            if ($urandom_range(5) == 0) pulse_clear();
            send_sample(16'($urandom), -9, '0, -9, -2);
            if ($urandom_range(2) != 0) quiet(int'($urandom_range(3)) + 1);
        end

        // Reset mid-computation aborts the sample
        set_sec(0, 16384, 0, 0, -8192, 0);
        set_sec(1, 16384, 0, 0, 0, 0);
        pulse_clear();
        send_sample(16'd16384, -9, '0, -9, -2);
        quiet(2);
        d_in = 16'd1000;
        pcm_valid = 1'b1;
        tick();
        pcm_valid = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_d_out", d_out, 0);
        chk("abort_sat", sat, 0);
        chk("abort_overrun", overrun, 0);
        quiet(20);
        send_sample(16'd0, -9, '0, -9, -2);
        chk("abort_lines_zero", $signed(d_out), 0);
        quiet(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
